dcache_tag_ram: RTL and testbench
=================================

Name: dcache_tag_ram

Overview:
- Simple-dual-port synchronous RAM that holds the data-cache tag array: 512 entries × 21 bits by default.
- One write port and one read port, both on a single clock.
- Sits beside the D-cache data RAM. The cache controller writes tags on line fill and reads them for hit compare.
- Read data arrives one cycle after the address (no output register by default).

Parameters:
- ADDR_WIDTH, 9, address bits on both ports; depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 21, tag word width on both ports.
- OUTPUT_REG, 0, 1 adds a second read pipeline register, making read latency 2.
- MEM_INIT_VAL, 0, value loaded into every entry at elaboration/power-up (simulation and FPGA init).

Ports:
- clk  in  1  single clock for both ports; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd_addr  in  ADDR_WIDTH  read address, sampled every cycle; there is no read enable.
- rd_data  out  DATA_WIDTH  read data.

Behaviour:
- Storage: array of 2**ADDR_WIDTH words × DATA_WIDTH, no parity, no byte enables.
- Write: at a rising edge with wr_en=1 and rst=0, mem[wr_addr] <= wr_data. Writes are ignored while rst=1.
- Read, OUTPUT_REG=0: at every rising edge with rst=0, rd_data <= mem[rd_addr]. Data for the address presented in cycle N is valid after edge N+1, and rd_data holds it until the next edge.
- Read, OUTPUT_REG=1: an extra register stage follows the array read; latency is 2 cycles; both stages advance every cycle.
- Reset: while rst=1 at an edge, rd_data and every pipeline stage load 0. Memory contents are NOT cleared; entries not written since power-up keep MEM_INIT_VAL.
- Same-address collision (wr_en=1, wr_addr==rd_addr, same edge): read-first. rd_data returns the old contents, and the new value is visible from the next read.
- Addresses are used modulo depth; there is no out-of-range case.
- Back-to-back reads and writes are allowed every cycle; there are no stalls and no handshake.
- Global power-on reset is via the technology GTP_GRS primitive. The block does not instantiate it; rst is the only functional reset.

Decomposition:
- Shared package: DCACHE_TAG_ADDR_W=9 and DCACHE_TAG_DATA_W=21 constants, plus a tag_word_t typedef for reuse by the cache controller.
- Natural sub-module: sdp_ram_core, a generic inferred memory array with registered read.
  - dcache_tag_ram wraps it and adds reset handling, the optional OUTPUT_REG stage and collision policy.

Test Plan:
- Reset, then idle with rst=1 for 20 cycles -> rd_data = 0 throughout; release rst -> rd_data = MEM_INIT_VAL (0) one cycle after the first address is sampled.
- Full fill/readback:
  - Stimulus: write address k (k=1..511, then 0) with data 0x200000−k mod 2^21, i.e. addr1=0x1FFFFF, addr2=0x1FFFFE, …, addr0=0x1FFE00. Then read addresses 1..511,0 on consecutive cycles.
  - Response: each rd_data matches one cycle after its address, with 0 mismatches.
- Collision: mem[5]=0x00AAA; on the same edge write 0x15555 to addr5 and read addr5 -> rd_data=0x00AAA; read addr5 on the next cycle -> 0x15555.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle during a streaming write of addr 10..20 with wr_en held high.
  - Response: rd_data=0 during rst; the write landing in the reset cycle is dropped (its old value is retained); all other addresses are intact.
- OUTPUT_REG=1 build: repeat the fill/readback -> data appears 2 cycles after the address; reset clears both stages to 0.
- Write disabled: wr_en=0 with varying wr_addr/wr_data for 50 cycles -> a subsequent readback equals the prior contents exactly.

Source files
------------

// File: rtl/dcache_tag_ram_pkg.sv
// Shared constants and types for the data-cache tag array.
// The cache controller imports this package to size its tag compare logic.
package dcache_tag_ram_pkg;

  localparam int DCACHE_TAG_ADDR_W = 9;
  localparam int DCACHE_TAG_DATA_W = 21;
  localparam int DCACHE_TAG_DEPTH  = 2 ** DCACHE_TAG_ADDR_W;

  typedef logic [DCACHE_TAG_DATA_W-1:0] tag_word_t;
  typedef logic [DCACHE_TAG_ADDR_W-1:0] tag_addr_t;

endpackage

// File: rtl/dcache_tag_ram_core.sv
// Generic simple-dual-port inferred memory with a registered read port.
// The read register has a synchronous clear so it maps onto the block RAM output latch reset.
module sdp_ram_core #(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    DATA_WIDTH = 21,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_rst,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Power-up contents come from the bitstream / simulator, never from a reset.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: INIT_VAL};
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Non-blocking read beside the write gives read-first behaviour on a collision.
  always_ff @(posedge clk) begin
    if (rd_rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dcache_tag_ram.sv
// Data-cache tag array: one write port, one read port, 1 or 2 cycle read latency.
// Reset clears only the read pipeline; stored tags survive it.
module dcache_tag_ram
  import dcache_tag_ram_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = DCACHE_TAG_ADDR_W,
  parameter int                    DATA_WIDTH   = DCACHE_TAG_DATA_W,
  parameter bit                    OUTPUT_REG   = 1'b0,
  parameter logic [DATA_WIDTH-1:0] MEM_INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic                  wr_en_gated;
  logic [DATA_WIDTH-1:0] core_rd_data;

  // A write that coincides with reset is dropped so a line fill interrupted by reset cannot land.
  assign wr_en_gated = wr_en & ~rst;

  sdp_ram_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .INIT_VAL   (MEM_INIT_VAL)
  ) u_core (
    .clk     (clk),
    .wr_en   (wr_en_gated),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_rst  (rst),
    .rd_addr (rd_addr),
    .rd_data (core_rd_data)
  );

  generate
    if (OUTPUT_REG) begin : g_out_reg
      logic [DATA_WIDTH-1:0] out_d;
      logic [DATA_WIDTH-1:0] out_q;

      always_comb begin
        out_d = core_rd_data;
        if (rst) begin
          out_d = '0;
        end
      end

      always_ff @(posedge clk) begin
        out_q <= out_d;
      end

      assign rd_data = out_q;
    end else begin : g_no_out_reg
      assign rd_data = core_rd_data;
    end
  endgenerate

endmodule

// File: tb/tb_dcache_tag_ram.sv
// Self-checking bench: one latency-1 and one latency-2 instance share stimulus;
// a reference memory predicts each read and a queue pairs predictions with outputs.
module tb_dcache_tag_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [8:0]  wr_addr = '0;
  logic [20:0] wr_data = '0;
  logic [8:0]  rd_addr = '0;
  logic [20:0] rd_data0;
  logic [20:0] rd_data1;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [8:0]  ra;
    logic [20:0] d0;
    logic [20:0] d1;
  } exp_t;

  exp_t        sb[$];
  logic [20:0] model_mem [512];
  logic [20:0] stage1_m = '0;

  always #5 clk = ~clk;

  dcache_tag_ram #(.ADDR_WIDTH(9), .DATA_WIDTH(21), .OUTPUT_REG(1'b0), .MEM_INIT_VAL(21'h0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data0)
  );

  dcache_tag_ram #(.ADDR_WIDTH(9), .DATA_WIDTH(21), .OUTPUT_REG(1'b1), .MEM_INIT_VAL(21'h0)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data1)
  );

  // Drive one cycle, push the predicted outputs for after the coming edge, then wait past that edge.
  task automatic step(input logic r, input logic we, input logic [8:0] wa,
                      input logic [20:0] wd, input logic [8:0] ra);
    exp_t e;
    @(negedge clk);
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra;
    e.ra = ra;
    e.d0 = r ? 21'h0 : model_mem[ra];
    e.d1 = r ? 21'h0 : stage1_m;
    stage1_m = e.d0;
    if (!r && we) model_mem[wa] = wd;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 9'(i), 21'h1F0F0, 9'($urandom_range(0, 511)));
      e = sb.pop_front();
      total++;
      if (rd_data0 === 21'h0) passed++;
      else $display("FAIL reset_hold lat1 cyc=%0d got=%h exp=000000", i, rd_data0);
      total++;
      if (rd_data1 === 21'h0) passed++;
      else $display("FAIL reset_hold lat2 cyc=%0d got=%h exp=000000", i, rd_data1);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 9'h0, 21'h0, 9'(7 + i));
      e = sb.pop_front();
      total++;
      if (rd_data0 === e.d0) passed++;
      else $display("FAIL reset_release lat1 addr=%h got=%h exp=%h", e.ra, rd_data0, e.d0);
      total++;
      if (rd_data1 === e.d1) passed++;
      else $display("FAIL reset_release lat2 addr=%h got=%h exp=%h", e.ra, rd_data1, e.d1);
    end
    // Entries never written hold the power-up value
    total++;
    if (rd_data0 === 21'h0) passed++;
    else $display("FAIL reset_init_val got=%h exp=000000", rd_data0);
  endtask

  task automatic test_fill_readback();
    exp_t        e;
    logic [21:0] full;
    for (int k = 1; k <= 512; k++) begin
      full = 22'h200000 - 22'(k);
      step(1'b0, 1'b1, 9'(k), full[20:0], 9'(k + 100));
      e = sb.pop_front();
      total++;
      if (rd_data0 === e.d0) passed++;
      else $display("FAIL fill_during lat1 addr=%h got=%h exp=%h", e.ra, rd_data0, e.d0);
    end
    for (int k = 1; k <= 514; k++) begin
      step(1'b0, 1'b0, 9'h0, 21'h0, 9'(k));
      e = sb.pop_front();
      total++;
      if (rd_data0 === e.d0) passed++;
      else $display("FAIL fill_readback lat1 addr=%h got=%h exp=%h", e.ra, rd_data0, e.d0);
      total++;
      if (rd_data1 === e.d1) passed++;
      else $display("FAIL fill_readback lat2 addr=%h got=%h exp=%h", e.ra, rd_data1, e.d1);
    end
    // Address 0 was the last write and must hold 0x1FFE00
    step(1'b0, 1'b0, 9'h0, 21'h0, 9'h0);
    e = sb.pop_front();
    total++;
    if (rd_data0 === 21'h1FFE00) passed++;
    else $display("FAIL fill_addr0 got=%h exp=1ffe00", rd_data0);
  endtask

  task automatic test_collision();
    exp_t e;
    step(1'b0, 1'b1, 9'd5, 21'h00AAA, 9'd0);
    void'(sb.pop_front());
    step(1'b0, 1'b1, 9'd5, 21'h15555, 9'd5);
    e = sb.pop_front();
    total++;
    if (rd_data0 === 21'h00AAA) passed++;
    else $display("FAIL collision_old got=%h exp=000aaa", rd_data0);
    step(1'b0, 1'b0, 9'd0, 21'h0, 9'd5);
    e = sb.pop_front();
    total++;
    if (rd_data0 === 21'h15555) passed++;
    else $display("FAIL collision_new got=%h exp=015555", rd_data0);
    total++;
    if (rd_data1 === 21'h00AAA) passed++;
    else $display("FAIL collision_old lat2 got=%h exp=000aaa", rd_data1);
    step(1'b0, 1'b0, 9'd0, 21'h0, 9'd0);
    e = sb.pop_front();
    total++;
    if (rd_data1 === 21'h15555) passed++;
    else $display("FAIL collision_new lat2 got=%h exp=015555", rd_data1);
  endtask

  task automatic test_reset_mid();
    exp_t        e;
    logic [20:0] old15;
    old15 = model_mem[15];
    for (int a = 10; a <= 20; a++) begin
      step(a == 15, 1'b1, 9'(a), 21'(32'h0ABC00 + a), 9'(a));
      e = sb.pop_front();
      total++;
      if (rd_data0 === e.d0) passed++;
      else $display("FAIL reset_mid stream lat1 addr=%h got=%h exp=%h", e.ra, rd_data0, e.d0);
      total++;
      if (rd_data1 === e.d1) passed++;
      else $display("FAIL reset_mid stream lat2 addr=%h got=%h exp=%h", e.ra, rd_data1, e.d1);
    end
    for (int a = 10; a <= 21; a++) begin
      step(1'b0, 1'b0, 9'h0, 21'h0, 9'(a));
      e = sb.pop_front();
      total++;
      if (rd_data0 === e.d0) passed++;
      else $display("FAIL reset_mid readback addr=%h got=%h exp=%h", e.ra, rd_data0, e.d0);
      if (a == 15) begin
        total++;
        if (rd_data0 === old15) passed++;
        else $display("FAIL reset_mid dropped_write got=%h exp=%h", rd_data0, old15);
      end
    end
  endtask

  task automatic test_wr_disabled();
    exp_t e;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0, 9'($urandom_range(0, 511)), 21'($urandom), 9'($urandom_range(0, 511)));
      void'(sb.pop_front());
    end
    for (int a = 0; a < 513; a++) begin
      step(1'b0, 1'b0, 9'h0, 21'h0, 9'(a));
      e = sb.pop_front();
      total++;
      if (rd_data0 === e.d0) passed++;
      else $display("FAIL wr_disabled lat1 addr=%h got=%h exp=%h", e.ra, rd_data0, e.d0);
      total++;
      if (rd_data1 === e.d1) passed++;
      else $display("FAIL wr_disabled lat2 addr=%h got=%h exp=%h", e.ra, rd_data1, e.d1);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'($urandom), 9'($urandom_range(0, 15)), 21'($urandom), 9'($urandom_range(0, 15)));
      e = sb.pop_front();
      total++;
      if (rd_data0 === e.d0) passed++;
      else $display("FAIL back_to_back lat1 addr=%h got=%h exp=%h", e.ra, rd_data0, e.d0);
      total++;
      if (rd_data1 === e.d1) passed++;
      else $display("FAIL back_to_back lat2 addr=%h got=%h exp=%h", e.ra, rd_data1, e.d1);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) model_mem[i] = 21'h0;
    test_reset();
    test_fill_readback();
    test_collision();
    test_reset_mid();
    test_wr_disabled();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
